// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshake and a NOP-loading flush.
// Optional statistics counters are enabled by defining PIPE_SKID_REG_STATS_EN.
module pipe_skid_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i
`ifdef PIPE_SKID_REG_STATS_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [15:0]      flush_cnt_o
`endif
);

  // State is the pair {m_vld, s_vld}; 2'b01 cannot be reached.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] s_data;
  logic             m_vld;
  logic             s_vld;
  logic             acc;
  logic             pop;

  // ready_o comes straight from the s_vld flop, so no input reaches it combinationally.
  assign ready_o = ~s_vld;
  assign valid_o = m_vld;
  assign data_o  = m_data;

  assign acc = valid_i & ready_o;
  assign pop = m_vld & ready_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      m_vld  <= 1'b0;
      s_vld  <= 1'b0;
      m_data <= NOP_VALUE;
      s_data <= NOP_VALUE;
    end else begin
      case ({m_vld, s_vld})
        EMPTY: begin
          if (acc) begin
            m_vld  <= 1'b1;
            m_data <= data_i;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            s_vld  <= 1'b1;
            s_data <= data_i;
          end else if (acc && pop) begin
            m_data <= data_i;
          end else if (pop) begin
            m_vld  <= 1'b0;
            m_data <= NOP_VALUE;
          end
        end
        FULL: begin
          // ready_o is low here, so only a drain into the main register can happen.
          if (pop) begin
            m_data <= s_data;
            s_data <= NOP_VALUE;
            s_vld  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_SKID_REG_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Counters saturate and are cleared only by reset, never by flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_vld && !ready_i && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_i && (flush_cnt != '1))           flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a monitor checks outputs every cycle against a FIFO model,
// and directed scenarios compare the delivered sequence with hand-computed expectations.
module tb_pipe_skid_reg;
  localparam int           W   = 64;
  localparam logic [W-1:0] NOP = 64'hDEAD_BEEF_0000_0001;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
`ifdef PIPE_SKID_REG_STATS_EN
  logic [31:0]  stall_cnt_o;
  logic [15:0]  flush_cnt_o;
`endif

  pipe_skid_reg #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
`ifdef PIPE_SKID_REG_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  int           pop_cyc[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares outputs with the FIFO model each cycle, logs delivered items, then advances the model.
  initial begin
    logic exp_ready;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      cyc++;
      exp_ready = (exp_q.size() < 2);
      check("ready_o", W'(ready_o), W'(exp_ready));
      check("valid_o", W'(valid_o), W'(exp_q.size() > 0));
      check("data_o", data_o, (exp_q.size() > 0) ? exp_q[0] : NOP);
      if (valid_o && ready_i) begin
        out_log.push_back(data_o);
        pop_cyc.push_back(cyc);
      end
      if (exp_q.size() > 0 && ready_i) void'(exp_q.pop_front());
      if (rst_i || flush_i) exp_q.delete();
      else if (valid_i && exp_ready) exp_q.push_back(data_i);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    tick();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b0, {$urandom, $urandom}, r);
  endtask

  task automatic clear_log();
    out_log.delete();
    pop_cyc.delete();
  endtask

  task automatic check_log(input string name, input logic [W-1:0] exp[$]);
    check({name, "_len"}, W'(out_log.size()), W'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      check(name, out_log[i], exp[i]);
  endtask

  initial begin
    logic [W-1:0] want[$];

    // Reset then idle
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_valid", W'(valid_o), '0);
    check("rst_ready", W'(ready_o), W'(1));
    check("rst_data", data_o, NOP);
    idle(2, 1'b1);

    // Streaming 1..8 with ready_i steady high
    clear_log();
    for (int k = 1; k <= 8; k++) drive(1'b1, W'(k), 1'b1);
    idle(3, 1'b1);
    want.delete();
    for (int k = 1; k <= 8; k++) want.push_back(W'(k));
    check_log("stream", want);
    if (pop_cyc.size() == 8) check("stream_span", W'(pop_cyc[7] - pop_cyc[0]), W'(7));

    // Backpressure into the skid register, then drain
    clear_log();
    drive(1'b1, 64'hA, 1'b0);
    drive(1'b1, 64'hB, 1'b0);
    idle(3, 1'b0);
    check("bp_ready", W'(ready_o), '0);
    check("bp_valid", W'(valid_o), W'(1));
    check("bp_data", data_o, 64'hA);
    idle(3, 1'b1);
    want = '{64'hA, 64'hB};
    check_log("bp", want);
    check("bp_end_valid", W'(valid_o), '0);
    check("bp_end_data", data_o, NOP);

    // Flush while FULL with a same-cycle valid_i of 0xC
    clear_log();
    drive(1'b1, 64'h3, 1'b0);
    drive(1'b1, 64'h4, 1'b0);
    flush_i = 1'b1;
    drive(1'b1, 64'hC, 1'b0);
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("fl_valid", W'(valid_o), '0);
    check("fl_ready", W'(ready_o), W'(1));
    check("fl_data", data_o, NOP);
    idle(3, 1'b1);
    want.delete();
    check_log("fl_full", want);

    // Flush in ONE with a same-cycle pop of 0x7 and acc of 0xD
    clear_log();
    drive(1'b1, 64'h7, 1'b0);
    flush_i = 1'b1;
    drive(1'b1, 64'hD, 1'b1);
    flush_i = 1'b0;
    idle(3, 1'b1);
    want = '{64'h7};
    check_log("fl_one", want);

    // Reset beats flush and acc
    clear_log();
    drive(1'b1, 64'h5, 1'b0);
    rst_i   = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 64'h6, 1'b0);
    rst_i   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("rp_valid", W'(valid_o), '0);
    check("rp_ready", W'(ready_o), W'(1));
    check("rp_data", data_o, NOP);
    idle(3, 1'b1);
    want.delete();
    check_log("rp", want);

`ifdef PIPE_SKID_REG_STATS_EN
    rst_i = 1'b1;
    idle(1, 1'b1);
    rst_i = 1'b0;
    drive(1'b1, 64'h9, 1'b0);
    idle(7, 1'b0);
    flush_i = 1'b1;
    idle(2, 1'b1);
    flush_i = 1'b0;
    check("stall_cnt", W'(stall_cnt_o), W'(7));
    check("flush_cnt", W'(flush_cnt_o), W'(2));
`endif

    idle(2, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register for the 5-stage CPU. Next generation of the fixed 32-bit IF/ID latch.
- Arbitrary payload width (e.g. PC+instr = 64 bits).
- Valid/ready handshake with a 2-entry skid buffer, so ready_o is registered and never combinationally depends on ready_i.
- Flush loads a configurable NOP payload. Used between IF/ID, ID/EX and EX/MEM.

Parameters:
- WIDTH, 64, payload width in bits (min 1).
- NOP_VALUE, {WIDTH{1'b0}}, payload driven on data_o whenever valid_o=0 and loaded on flush.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all held entries and the same-cycle input.
- valid_i  in  1  upstream payload valid.
- data_i  in  WIDTH  upstream payload.
- ready_o  out  1  stage can accept; registered.
- valid_o  out  1  downstream payload valid.
- data_o  out  WIDTH  downstream payload (main register).
- ready_i  in  1  downstream accepts; ready_i=0 replaces the old stall_i.

Behaviour:
- Definitions: acc = valid_i && ready_o; pop = valid_o && ready_i.
- Storage: main register (m_data, m_vld) and skid register (s_data, s_vld).
- State encoding: EMPTY (m_vld=0, s_vld=0), ONE (m_vld=1, s_vld=0), FULL (both set). The state {m_vld=0, s_vld=1} is illegal and never reachable.
- Outputs: valid_o=m_vld; data_o=m_data; ready_o = !s_vld, taken from a register, no combinational path from ready_i or valid_i.
- Reset (rst_i=1 at a posedge): state EMPTY, m_data=s_data=NOP_VALUE, so valid_o=0, ready_o=1, data_o=NOP_VALUE. Reset wins over flush and handshakes, including mid-transfer; any held entries are lost.
- Flush (rst_i=0, flush_i=1): same register values as reset. A same-cycle acc is dropped, and a same-cycle pop still counts as consumed downstream.
- Transitions, no reset or flush:
  - EMPTY, acc: go to ONE, m_data<=data_i.
  - EMPTY, no acc: hold.
  - ONE, acc && !pop: go to FULL, s_data<=data_i.
  - ONE, acc && pop: stay ONE, m_data<=data_i.
  - ONE, !acc && pop: go to EMPTY, m_data<=NOP_VALUE.
  - ONE, neither: hold; data_o stable.
  - FULL, pop: go to ONE, m_data<=s_data, s_data<=NOP_VALUE. acc is impossible here since ready_o=0.
  - FULL, no pop: hold both.
- Latency: 1 cycle from acc to valid_o when the stage is empty.
- Throughput: 1 item/cycle sustained when ready_i=1 steadily.
- Ordering: strict FIFO; no duplication or loss except on flush/reset.
- data_o and valid_o must stay stable while valid_o=1 and ready_i=0.
- valid_i=0 with arbitrary data_i: no state change.
- Upstream contract: once valid_i is asserted, the upstream holds it and data_i until acc. The stage does not check this.

Optional Feature:
- Macro: PIPE_SKID_REG_STATS_EN.
- When defined, two extra output ports are added:
  - stall_cnt_o (32): counts cycles with valid_o=1 && ready_i=0.
  - flush_cnt_o (16): counts cycles with flush_i=1 && rst_i=0.
- Both counters saturate at all-ones, are cleared by rst_i, and are unaffected by flush.
- When not defined, the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, then 0 → valid_o=0, ready_o=1, data_o=NOP_VALUE.
- Streaming: ready_i=1, push 0x1..0x8 on consecutive cycles → data_o shows 0x1..0x8 on consecutive cycles starting 1 cycle after the first acc; ready_o stays 1.
- Backpressure/skid:
  - Push 0xA and 0xB with ready_i=0 → FULL, ready_o=0, data_o=0xA held stable.
  - Raise ready_i → 0xA then 0xB in order, then valid_o=0 and data_o=NOP_VALUE.
- Flush in FULL with a same-cycle valid_i carrying 0xC:
  - Next cycle: valid_o=0, ready_o=1, data_o=NOP_VALUE.
  - 0xC never appears.
- Reset priority: in ONE holding 0x5, assert rst_i and flush_i with acc of 0x6 → EMPTY, data_o=NOP_VALUE; 0x6 never appears.
- With PIPE_SKID_REG_STATS_EN: hold valid_o=1, ready_i=0 for 7 cycles, then pulse flush_i for 2 cycles → stall_cnt_o=7, flush_cnt_o=2.
